// File: rtl/op_fifo_unit_if.sv
// rtl/op_fifo_unit_if.sv - write/read method bus and status flags of op_fifo_unit
interface op_fifo_unit_if #(
  parameter int DATA_W = 8
);
  logic [2:0]        write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_en;
  logic              write_rdy;
  logic [2:0]        read_address;
  logic              read_en;
  logic [DATA_W-1:0] read_data;
  logic              read_rdy;
  logic              a_full_n;
  logic              b_full_n;
  logic              y_empty_n;

  modport master (
    output write_address, write_data, write_en,
    output read_address, read_en,
    input  write_rdy, read_data, read_rdy,
    input  a_full_n, b_full_n, y_empty_n
  );

  modport slave (
    input  write_address, write_data, write_en,
    input  read_address, read_en,
    output write_rdy, read_data, read_rdy,
    output a_full_n, b_full_n, y_empty_n
  );
endinterface

// File: rtl/op_fifo_unit.sv
// rtl/op_fifo_unit.sv - two operand FIFOs, selectable-op compute stage, result FIFO
module op_fifo_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  op_fifo_unit_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_ADD = 2'b11
  } mode_t;

  // method readiness
  logic rdy_q;
  logic wr_fire;
  logic rd_fire;

  // FIFO storage
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [DATA_W-1:0] mem_y [DEPTH];

  // pointers and occupancy
  logic [PW-1:0] a_wr_ptr, a_rd_ptr;
  logic [PW-1:0] b_wr_ptr, b_rd_ptr;
  logic [PW-1:0] y_wr_ptr, y_rd_ptr;
  logic [CW-1:0] cnt_a, cnt_b, cnt_y;

  // fullness / emptiness from pre-edge counts only
  logic a_full, b_full, y_full;
  logic a_empty, b_empty, y_empty;

  // per-cycle actions
  logic a_push_req, b_push_req, y_pop_req, ctrl_wr;
  logic a_push, b_push, y_pop;
  logic compute;
  logic a_ovf_set, b_ovf_set, y_udf_set;

  // control / status
  mode_t mode;
  logic  a_ovf, b_ovf, y_udf;

  logic [DATA_W-1:0] a_head, b_head, y_head;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] rdata;

  // methods become ready on the first edge after reset release
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  assign bus.write_rdy = rdy_q;
  assign bus.read_rdy  = rdy_q;
  assign wr_fire       = bus.write_en & rdy_q;
  assign rd_fire       = bus.read_en & rdy_q;

  assign a_full  = (cnt_a == FULL_CNT);
  assign b_full  = (cnt_b == FULL_CNT);
  assign y_full  = (cnt_y == FULL_CNT);
  assign a_empty = (cnt_a == '0);
  assign b_empty = (cnt_b == '0);
  assign y_empty = (cnt_y == '0);

  assign bus.a_full_n  = ~a_full;
  assign bus.b_full_n  = ~b_full;
  assign bus.y_empty_n = ~y_empty;

  assign a_head = mem_a[a_rd_ptr];
  assign b_head = mem_b[b_rd_ptr];
  assign y_head = mem_y[y_rd_ptr];

  // decode method strobes into FIFO actions; no bypass between push and pop
  always_comb begin
    a_push_req = wr_fire && (bus.write_address == 3'd4);
    b_push_req = wr_fire && (bus.write_address == 3'd5);
    ctrl_wr    = wr_fire && (bus.write_address == 3'd6);
    y_pop_req  = rd_fire && (bus.read_address == 3'd3);

    a_push    = a_push_req && !a_full;
    b_push    = b_push_req && !b_full;
    y_pop     = y_pop_req && !y_empty;
    a_ovf_set = a_push_req && a_full;
    b_ovf_set = b_push_req && b_full;
    y_udf_set = y_pop_req && y_empty;

    compute   = !a_empty && !b_empty && !y_full;
  end

  // operation applied to the operand heads under the current mode
  always_comb begin
    result = '0;
    case (mode)
      MODE_OR:  result = a_head | b_head;
      MODE_AND: result = a_head & b_head;
      MODE_XOR: result = a_head ^ b_head;
      MODE_ADD: result = a_head + b_head;
      default:  result = '0;
    endcase
  end

  // FIFO payload storage; contents are don't-care until counted valid
  always_ff @(posedge CLK) begin
    if (a_push) begin
      mem_a[a_wr_ptr] <= bus.write_data;
    end
    if (b_push) begin
      mem_b[b_wr_ptr] <= bus.write_data;
    end
    if (compute) begin
      mem_y[y_wr_ptr] <= result;
    end
  end

  // operand A pointers and occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_wr_ptr <= '0;
      a_rd_ptr <= '0;
      cnt_a    <= '0;
    end else begin
      if (a_push) begin
        a_wr_ptr <= a_wr_ptr + 1'b1;
      end
      if (compute) begin
        a_rd_ptr <= a_rd_ptr + 1'b1;
      end
      cnt_a <= cnt_a + CW'(a_push) - CW'(compute);
    end
  end

  // operand B pointers and occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      b_wr_ptr <= '0;
      b_rd_ptr <= '0;
      cnt_b    <= '0;
    end else begin
      if (b_push) begin
        b_wr_ptr <= b_wr_ptr + 1'b1;
      end
      if (compute) begin
        b_rd_ptr <= b_rd_ptr + 1'b1;
      end
      cnt_b <= cnt_b + CW'(b_push) - CW'(compute);
    end
  end

  // result Y pointers and occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_wr_ptr <= '0;
      y_rd_ptr <= '0;
      cnt_y    <= '0;
    end else begin
      if (compute) begin
        y_wr_ptr <= y_wr_ptr + 1'b1;
      end
      if (y_pop) begin
        y_rd_ptr <= y_rd_ptr + 1'b1;
      end
      cnt_y <= cnt_y + CW'(compute) - CW'(y_pop);
    end
  end

  // mode register and sticky error flags; a new error beats a same-cycle clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode  <= MODE_OR;
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
      y_udf <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        mode <= mode_t'(bus.write_data[1:0]);
      end
      if (ctrl_wr && bus.write_data[2]) begin
        a_ovf <= a_ovf_set;
        b_ovf <= b_ovf_set;
        y_udf <= y_udf_set;
      end else begin
        a_ovf <= a_ovf | a_ovf_set;
        b_ovf <= b_ovf | b_ovf_set;
        y_udf <= y_udf | y_udf_set;
      end
    end
  end

  // read mux, combinational from address and current state
  always_comb begin
    rdata = '0;
    if (rd_fire) begin
      case (bus.read_address)
        3'd0:    rdata = DATA_W'(bus.a_full_n);
        3'd1:    rdata = DATA_W'(bus.b_full_n);
        3'd2:    rdata = DATA_W'(bus.y_empty_n);
        3'd3:    rdata = y_empty ? '0 : y_head;
        3'd4:    rdata = DATA_W'(cnt_a);
        3'd5:    rdata = DATA_W'(cnt_b);
        3'd6:    rdata = DATA_W'(cnt_y);
        3'd7:    rdata = {{(DATA_W-5){1'b0}}, mode, y_udf, b_ovf, a_ovf};
        default: rdata = '0;
      endcase
    end
  end

  assign bus.read_data = rdata;

endmodule

// File: tb/tb_op_fifo_unit.sv
// tb/tb_op_fifo_unit.sv - directed self-checking bench for op_fifo_unit
module tb_op_fifo_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  op_fifo_unit_if #(.DATA_W(8)) bus ();

  op_fifo_unit #(.DATA_W(8), .DEPTH(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.write_address = a;
    bus.write_data    = d;
    bus.write_en      = 1'b1;
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
    bus.read_address = a;
    bus.read_en      = 1'b1;
    #1;
    check(tag, bus.read_data, exp);
    @(posedge clk);
    #1;
    bus.read_en = 1'b0;
  endtask

  task automatic peek(input logic [2:0] a, input logic [7:0] exp, input string tag);
    bus.read_address = a;
    bus.read_en      = 1'b1;
    #1;
    check(tag, bus.read_data, exp);
    bus.read_en = 1'b0;
  endtask

  task automatic wr_rd(input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] ra, input logic [7:0] exp, input string tag);
    bus.write_address = wa;
    bus.write_data    = wd;
    bus.write_en      = 1'b1;
    bus.read_address  = ra;
    bus.read_en       = 1'b1;
    #1;
    check(tag, bus.read_data, exp);
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    bus.write_address = '0;
    bus.write_data    = '0;
    bus.write_en      = 1'b0;
    bus.read_address  = '0;
    bus.read_en       = 1'b0;

    // reset values
    #3;
    check("rst_write_rdy", {7'd0, bus.write_rdy}, 8'h00);
    check("rst_read_rdy",  {7'd0, bus.read_rdy},  8'h00);
    check("rst_a_full_n",  {7'd0, bus.a_full_n},  8'h01);
    check("rst_b_full_n",  {7'd0, bus.b_full_n},  8'h01);
    check("rst_y_empty_n", {7'd0, bus.y_empty_n}, 8'h00);
    #9 rst_n = 1'b1;
    cycles(1);
    check("write_rdy_up", {7'd0, bus.write_rdy}, 8'h01);
    check("read_rdy_up",  {7'd0, bus.read_rdy},  8'h01);

    // OR mode and single-pair latency
    wr(3'd4, 8'h0F);
    wr(3'd5, 8'hF0);
    check("lat_not_yet", {7'd0, bus.y_empty_n}, 8'h00);
    cycles(1);
    check("lat_ready", {7'd0, bus.y_empty_n}, 8'h01);
    rd(3'd2, 8'h01, "addr2_nonempty");
    rd(3'd3, 8'hFF, "or_result");
    rd(3'd2, 8'h00, "addr2_empty");
    check("y_empty_n_after_pop", {7'd0, bus.y_empty_n}, 8'h00);

    // ADD with wrap, XOR, AND
    wr(3'd6, 8'h03);
    wr(3'd4, 8'hFF);
    wr(3'd5, 8'h02);
    cycles(1);
    rd(3'd3, 8'h01, "add_wrap");
    wr(3'd6, 8'h02);
    wr(3'd4, 8'hAA);
    wr(3'd5, 8'hFF);
    cycles(1);
    rd(3'd3, 8'h55, "xor_result");
    rd(3'd7, 8'h10, "status_xor_mode");
    wr(3'd6, 8'h01);
    wr(3'd4, 8'hCC);
    wr(3'd5, 8'hAA);
    cycles(1);
    rd(3'd3, 8'h88, "and_result");

    // backpressure: fill Y, then fill A, then overflow A
    wr(3'd6, 8'h03);
    for (int i = 1; i <= 4; i++) begin
      wr(3'd4, 8'(i));
      wr(3'd5, 8'(i * 16));
    end
    cycles(1);
    rd(3'd6, 8'h04, "y_count_full");
    rd(3'd4, 8'h00, "a_count_zero");
    rd(3'd5, 8'h00, "b_count_zero");
    for (int i = 5; i <= 8; i++) begin
      wr(3'd4, 8'(i));
    end
    rd(3'd4, 8'h04, "a_count_full");
    check("a_full_n_low", {7'd0, bus.a_full_n}, 8'h00);
    rd(3'd0, 8'h00, "addr0_full");
    wr(3'd4, 8'h09);
    rd(3'd4, 8'h04, "a_count_after_drop");
    rd(3'd7, 8'h19, "status_a_ovf");
    for (int i = 1; i <= 4; i++) begin
      rd(3'd3, 8'(i * 8'h11), "y_drain_first");
    end
    rd(3'd6, 8'h00, "y_count_drained");
    for (int i = 1; i <= 4; i++) begin
      wr(3'd5, 8'(i * 16));
    end
    cycles(1);
    rd(3'd4, 8'h00, "a_count_after_refill");
    rd(3'd5, 8'h00, "b_count_after_refill");
    rd(3'd6, 8'h04, "y_count_refill");
    for (int i = 1; i <= 4; i++) begin
      rd(3'd3, 8'((i + 4) + i * 16), "y_drain_second");
    end

    // underflow and sticky clear
    rd(3'd3, 8'h00, "udf_data");
    rd(3'd7, 8'h1D, "status_udf");
    wr(3'd6, 8'h04);
    rd(3'd7, 8'h00, "status_cleared");
    wr_rd(3'd6, 8'h04, 3'd3, 8'h00, "udf_with_clear");
    rd(3'd7, 8'h04, "set_beats_clear");
    wr(3'd6, 8'h04);
    rd(3'd7, 8'h00, "status_cleared2");

    // underflow while compute pushes the same edge: entry retained
    wr(3'd4, 8'h11);
    wr(3'd5, 8'h22);
    rd(3'd3, 8'h00, "udf_vs_push");
    rd(3'd6, 8'h01, "y_retained");
    rd(3'd3, 8'h33, "retained_value");
    rd(3'd7, 8'h04, "status_udf2");
    wr(3'd6, 8'h04);

    // same-cycle B push completing a pair and pop of the last Y entry
    wr(3'd4, 8'h01);
    wr(3'd5, 8'h02);
    cycles(1);
    wr(3'd4, 8'h30);
    wr_rd(3'd5, 8'h0C, 3'd3, 8'h03, "pop_old_entry");
    peek(3'd6, 8'h00, "y_count_after_pop");
    peek(3'd4, 8'h01, "a_count_pair");
    peek(3'd5, 8'h01, "b_count_pair");
    check("y_empty_between", {7'd0, bus.y_empty_n}, 8'h00);
    cycles(1);
    peek(3'd6, 8'h01, "y_count_new");
    peek(3'd4, 8'h00, "a_count_consumed");
    rd(3'd3, 8'h3C, "new_result");

    // asynchronous reset mid-stream
    wr(3'd6, 8'h03);
    for (int i = 1; i <= 3; i++) begin
      wr(3'd4, 8'(i));
      wr(3'd5, 8'(i));
    end
    wr(3'd4, 8'h0A);
    wr(3'd4, 8'h0B);
    peek(3'd4, 8'h02, "a_count_pre_rst");
    peek(3'd6, 8'h03, "y_count_pre_rst");
    #1 rst_n = 1'b0;
    #1;
    check("async_write_rdy", {7'd0, bus.write_rdy}, 8'h00);
    check("async_read_rdy",  {7'd0, bus.read_rdy},  8'h00);
    check("async_y_empty_n", {7'd0, bus.y_empty_n}, 8'h00);
    check("async_a_full_n",  {7'd0, bus.a_full_n},  8'h01);
    #1 rst_n = 1'b1;
    cycles(1);
    check("rdy_after_rst", {7'd0, bus.write_rdy}, 8'h01);
    rd(3'd4, 8'h00, "a_count_post_rst");
    rd(3'd6, 8'h00, "y_count_post_rst");
    rd(3'd7, 8'h00, "status_post_rst");
    wr(3'd4, 8'h0F);
    wr(3'd5, 8'h0F);
    cycles(1);
    rd(3'd3, 8'h0F, "or_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
